// File: rtl/split_com_queue.sv
// split_com_queue
// Buffers split-completion records from the NearPM unit and presents them
// one at a time to the arbiter.
//
// A record is {split_id[11:0], dest_mask[7:0]}. Records whose destination
// mask is zero go nowhere, so they are dropped at the input and counted.
//
// The presented record sits in its own register, outside the FIFO.
// fifo_level therefore counts only the entries still waiting behind it.
//
// Arbiter handshake:
//   - The arbiter raises read_complete_split.
//   - Only the rising edge of that strobe consumes the presented record.
//   - The record stays frozen for one further HOLD cycle, so the arbiter
//     can sample it two cycles after the rise.
module split_com_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [11:0]              in_split_id,
    input  logic [7:0]               in_dest_mask,
    output logic [19:0]              complete_split,
    output logic                     pending_complete_split,
    input  logic                     read_complete_split,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    generate
        if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("split_com_queue: DEPTH must be a power of two in 2..256");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [19:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;

    logic            read_prev;
    logic            read_rise;
    logic            accept;
    logic            push;
    logic            drop;
    logic            pop;
    logic            clr_pending;

    // in_ready depends on the level alone, never on in_valid, so the
    // producer sees no combinational loop through this block.
    assign in_ready   = (level < LW'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign push       = accept && (in_dest_mask != 8'd0);
    assign drop       = accept && (in_dest_mask == 8'd0);
    assign read_rise  = read_complete_split && !read_prev;
    assign fifo_level = level;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // Pops happen only from IDLE, so nothing new replaces the presented
    // record while it is pending or in its HOLD cycle.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        clr_pending = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (read_rise) begin
                    clr_pending = 1'b1;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered copy of the read strobe.
    // A strobe held high for several cycles yields only one edge.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            read_prev <= 1'b0;
        end else begin
            read_prev <= read_complete_split;
        end
    end

    // FIFO storage.
    // Contents need no reset because the pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (aresetn && push) begin
            mem[wr_ptr] <= {in_split_id, in_dest_mask};
        end
    end

    // FIFO pointers and level.
    // A push and a pop in the same cycle cancel in the level.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Presented record.
    // Loaded only on a pop, so it is frozen through PRESENT and HOLD.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            complete_split <= 20'd0;
        end else if (pop) begin
            complete_split <= mem[rd_ptr];
        end
    end

    // Pending flag.
    // Set with the pop; cleared by the first read edge seen while presenting.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            pending_complete_split <= 1'b0;
        end else if (pop) begin
            pending_complete_split <= 1'b1;
        end else if (clr_pending) begin
            pending_complete_split <= 1'b0;
        end
    end

    // Saturating count of zero-mask records discarded at the input.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            drop_count <= 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_split_com_queue.sv
// Testbench for split_com_queue.
// A behavioural reference model runs alongside the DUT and is updated at
// every rising edge. Directed and randomized scenarios compare the DUT
// outputs against the model and against explicit constants.
`timescale 1ns/1ps
module tb_split_com_queue;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int VW    = 30 + LW;

    logic           clk = 1'b0;
    logic           aresetn = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [11:0]    in_split_id = '0;
    logic [7:0]     in_dest_mask = '0;
    logic [19:0]    complete_split;
    logic           pending_complete_split;
    logic           read_complete_split = 1'b0;
    logic [LW-1:0]  fifo_level;
    logic [7:0]     drop_count;

    int checks = 0;
    int errors = 0;

    split_com_queue #(.DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .aresetn                (aresetn),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_split_id            (in_split_id),
        .in_dest_mask           (in_dest_mask),
        .complete_split         (complete_split),
        .pending_complete_split (pending_complete_split),
        .read_complete_split    (read_complete_split),
        .fifo_level             (fifo_level),
        .drop_count             (drop_count)
    );

    always #5 clk = ~clk;

    // Observed output vector: {in_ready, pending, record, level, drops}
    logic [VW-1:0] obs;
    assign obs = {in_ready, pending_complete_split, complete_split, fifo_level, drop_count};

    // Reference model.
    // mq holds the waiting records. m_phase: 0 waiting to present,
    // 1 presenting, 2 one-cycle hold after consumption.
    logic [19:0] mq[$];
    bit          m_pend  = 1'b0;
    logic [19:0] m_rec   = '0;
    int          m_phase = 0;
    bit          m_prev  = 1'b0;
    int          m_drop  = 0;

    always @(posedge clk) begin
        bit acc;
        bit rise;
        bit popnow;
        if (!aresetn) begin
            mq.delete();
            m_pend  = 1'b0;
            m_rec   = '0;
            m_phase = 0;
            m_prev  = 1'b0;
            m_drop  = 0;
        end else begin
            acc    = in_valid && (mq.size() < DEPTH);
            rise   = read_complete_split && !m_prev;
            popnow = (m_phase == 0) && (mq.size() > 0);
            if (m_phase == 1 && rise) begin
                m_pend  = 1'b0;
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end
            if (popnow) begin
                m_rec   = mq.pop_front();
                m_pend  = 1'b1;
                m_phase = 1;
            end
            if (acc) begin
                if (in_dest_mask != 8'd0) mq.push_back({in_split_id, in_dest_mask});
                else if (m_drop < 255) m_drop++;
            end
            m_prev = read_complete_split;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        return {(mq.size() < DEPTH), m_pend, m_rec, LW'(mq.size()), m_drop[7:0]};
    endfunction

    // Advance one cycle; outputs are then sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        in_valid = 1'b0;
        read_complete_split = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        in_valid = 1'b1;
        in_split_id = 12'hABC;
        in_dest_mask = 8'h0F;
        read_complete_split = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 20'h0, LW'(0), 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, {1'b1, 1'b0, 20'h0, LW'(0), 8'h00});
        end
        aresetn = 1'b1;
        in_valid = 1'b0;
        tick();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1;
        in_split_id = 12'h123;
        in_dest_mask = 8'h03;
        tick();
        in_valid = 1'b0;
        checks++;
        if (pending_complete_split !== 1'b0 || fifo_level !== LW'(1)) begin
            errors++;
            $display("FAIL single_n1: pending %b level %0d want 0 1", pending_complete_split, fifo_level);
        end
        tick();
        checks++;
        if (pending_complete_split !== 1'b1 || complete_split !== 20'h12303 || fifo_level !== LW'(0)) begin
            errors++;
            $display("FAIL single_n2: pending %b rec %h level %0d want 1 12303 0",
                     pending_complete_split, complete_split, fifo_level);
        end
        read_complete_split = 1'b1;
        tick();
        read_complete_split = 1'b0;
        checks++;
        if (pending_complete_split !== 1'b0 || complete_split !== 20'h12303 || fifo_level !== LW'(0)) begin
            errors++;
            $display("FAIL single_read: pending %b rec %h level %0d want 0 12303 0",
                     pending_complete_split, complete_split, fifo_level);
        end
        tick();
        checks++;
        if (complete_split !== 20'h12303 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL single_hold: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_full();
        logic [19:0] pq[$];
        logic [19:0] rec;
        int acc = 0;
        int b;
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            rec = {12'($urandom), 8'($urandom_range(1, 255))};
            in_valid = 1'b1;
            {in_split_id, in_dest_mask} = rec;
            if (in_ready) begin
                acc++;
                pq.push_back(rec);
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL full_fill: got %h want %h", obs, exp_vec());
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (acc != DEPTH + 1) begin
            errors++;
            $display("FAIL full_accepted: got %0d want %0d", acc, DEPTH + 1);
        end
        checks++;
        if (in_ready !== 1'b0 || fifo_level !== LW'(DEPTH) || pending_complete_split !== 1'b1) begin
            errors++;
            $display("FAIL full_flags: ready %b level %0d pending %b want 0 %0d 1",
                     in_ready, fifo_level, pending_complete_split, DEPTH);
        end
        for (int k = 0; k < acc; k++) begin
            b = 0;
            while (!pending_complete_split && b < 10) begin
                tick();
                b++;
            end
            checks++;
            if (pending_complete_split !== 1'b1) begin
                errors++;
                $display("FAIL full_timeout: record %0d never presented", k);
            end else if (complete_split !== pq[0]) begin
                errors++;
                $display("FAIL full_order: record %0d got %h want %h", k, complete_split, pq[0]);
            end
            if (pq.size() > 0) void'(pq.pop_front());
            read_complete_split = 1'b1;
            tick();
            read_complete_split = 1'b0;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL full_drain: got %h want %h", obs, exp_vec());
            end
        end
        repeat (3) tick();
        checks++;
        if (pending_complete_split !== 1'b0 || fifo_level !== LW'(0) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_empty: pending %b level %0d ready %b want 0 0 1",
                     pending_complete_split, fifo_level, in_ready);
        end
    endtask

    task automatic test_zero_mask();
        logic [11:0] id;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_split_id = 12'($urandom);
            in_dest_mask = 8'h00;
            tick();
        end
        id = 12'($urandom);
        in_split_id = id;
        in_dest_mask = 8'h01;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (drop_count !== 8'd3 || pending_complete_split !== 1'b1 ||
            complete_split !== {id, 8'h01} || fifo_level !== LW'(0)) begin
            errors++;
            $display("FAIL zero_mask: drops %0d pending %b rec %h level %0d want 3 1 %h 0",
                     drop_count, pending_complete_split, complete_split, fifo_level, {id, 8'h01});
        end
        read_complete_split = 1'b1;
        tick();
        read_complete_split = 1'b0;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1;
            in_split_id = 12'($urandom);
            in_dest_mask = 8'h00;
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL zero_model: step %0d got %h want %h", i, obs, exp_vec());
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (drop_count !== 8'd255 || pending_complete_split !== 1'b0) begin
            errors++;
            $display("FAIL zero_saturate: drops %0d pending %b want 255 0", drop_count, pending_complete_split);
        end
    endtask

    task automatic test_spurious_read();
        logic [19:0] r1;
        logic [19:0] r2;
        int b;
        do_reset();
        read_complete_split = 1'b1;
        tick();
        read_complete_split = 1'b0;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 20'h0, LW'(0), 8'h00}) begin
            errors++;
            $display("FAIL idle_read: got %h want %h", obs, {1'b1, 1'b0, 20'h0, LW'(0), 8'h00});
        end
        r1 = {12'($urandom), 8'($urandom_range(1, 255))};
        r2 = {12'($urandom), 8'($urandom_range(1, 255))};
        in_valid = 1'b1;
        {in_split_id, in_dest_mask} = r1;
        tick();
        {in_split_id, in_dest_mask} = r2;
        tick();
        in_valid = 1'b0;
        b = 0;
        while (!pending_complete_split && b < 10) begin
            tick();
            b++;
        end
        checks++;
        if (pending_complete_split !== 1'b1 || complete_split !== r1) begin
            errors++;
            $display("FAIL long_first: pending %b rec %h want 1 %h", pending_complete_split, complete_split, r1);
        end
        read_complete_split = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL long_model: cycle %0d got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (pending_complete_split !== 1'b1 || complete_split !== r2 || fifo_level !== LW'(0)) begin
            errors++;
            $display("FAIL long_read: pending %b rec %h level %0d want 1 %h 0",
                     pending_complete_split, complete_split, fifo_level, r2);
        end
        read_complete_split = 1'b0;
        tick();
        checks++;
        if (pending_complete_split !== 1'b1 || complete_split !== r2) begin
            errors++;
            $display("FAIL long_fall: pending %b rec %h want 1 %h", pending_complete_split, complete_split, r2);
        end
        read_complete_split = 1'b1;
        tick();
        read_complete_split = 1'b0;
        checks++;
        if (pending_complete_split !== 1'b0) begin
            errors++;
            $display("FAIL long_second: pending %b want 0", pending_complete_split);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        do_reset();
        in_valid = 1'b1;
        in_split_id = 12'h055;
        in_dest_mask = 8'h00;
        tick();
        for (int i = 0; i < 6; i++) begin
            in_split_id = 12'($urandom);
            in_dest_mask = 8'($urandom_range(1, 255));
            tick();
        end
        in_valid = 1'b0;
        b = 0;
        while (!pending_complete_split && b < 10) begin
            tick();
            b++;
        end
        checks++;
        if (pending_complete_split !== 1'b1 || fifo_level !== LW'(5) || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_setup: pending %b level %0d drops %0d want 1 5 1",
                     pending_complete_split, fifo_level, drop_count);
        end
        read_complete_split = 1'b1;
        tick();
        read_complete_split = 1'b0;
        aresetn = 1'b0;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 20'h0, LW'(0), 8'h00}) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", obs, {1'b1, 1'b0, 20'h0, LW'(0), 8'h00});
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [19:0] sb[$];
        logic [19:0] rec;
        int arb = 0;
        int pushed = 0;
        int sampled = 0;
        bit done = 1'b0;
        do_reset();
        for (int c = 0; c < 3000 && !done; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model: cycle %0d got %h want %h", c, obs, exp_vec());
            end
            if (arb == 2) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: sampled %h with nothing expected", complete_split);
                end else begin
                    if (complete_split !== sb[0]) begin
                        errors++;
                        $display("FAIL b2b_order: sample %0d got %h want %h", sampled, complete_split, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                sampled++;
                arb = 0;
            end else if (arb == 1) begin
                read_complete_split = 1'b0;
                arb = 2;
            end else if (pending_complete_split) begin
                read_complete_split = 1'b1;
                arb = 1;
            end
            if (c < 500 && $urandom_range(0, 3) != 0) begin
                rec[19:8] = 12'($urandom);
                rec[7:0]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                in_valid = 1'b1;
                {in_split_id, in_dest_mask} = rec;
                if (in_ready && rec[7:0] != 8'h00) begin
                    sb.push_back(rec);
                    pushed++;
                end
            end else begin
                in_valid = 1'b0;
            end
            if (c >= 500 && sb.size() == 0 && arb == 0) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        read_complete_split = 1'b0;
        checks++;
        if (!done || sampled != pushed) begin
            errors++;
            $display("FAIL b2b_count: sampled %0d pushed %0d finished %0d", sampled, pushed, done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_full();
        test_zero_mask();
        test_spurious_read();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
